// File: rtl/ex_stage.sv
// Execute stage: registers the decode-to-execute bus, selects ALU operands,
// computes the ALU result, drives the data SRAM request and the
// execute-to-memory / forwarding buses. An iterative 32-step restoring
// divider (DIV/DIVU) writes internal HI/LO and requests a stall while busy.
module ex_stage #(
   parameter int ID_TO_EX_WD  = 159,
   parameter int EX_TO_MEM_WD = 76,
   parameter int STALL_WD     = 6
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [STALL_WD-1:0]     stall,
   input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
   output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
   output logic [37:0]             ex_to_id_fwd,
   output logic                    data_sram_en,
   output logic [3:0]              data_sram_wen,
   output logic [31:0]             data_sram_addr,
   output logic [31:0]             data_sram_wdata,
   output logic                    stallreq_for_ex
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } div_state_e;

   // ---------------------------------------------------------------
   // Decode-to-execute pipeline register
   // ---------------------------------------------------------------
   logic [ID_TO_EX_WD-1:0] r_bus;

   // Pipeline register: bubble when decode stops but execute runs, load when decode advances, else hold
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bus <= '0;
      end else if (stall[2] && !stall[3]) begin
         r_bus <= '0;
      end else if (!stall[2]) begin
         r_bus <= id_to_ex_bus;
      end else begin
         r_bus <= r_bus;
      end
   end

   logic [31:0] w_pc;
   logic [31:0] w_inst;
   logic [11:0] w_alu_op;
   logic [2:0]  w_sel_src1;
   logic [3:0]  w_sel_src2;
   logic        w_ram_en;
   logic [3:0]  w_ram_wen;
   logic        w_rf_we_raw;
   logic [4:0]  w_rf_waddr;
   logic        w_sel_rf_res;
   logic [31:0] w_rdata1;
   logic [31:0] w_rdata2;

   assign {w_pc, w_inst, w_alu_op, w_sel_src1, w_sel_src2, w_ram_en, w_ram_wen,
           w_rf_we_raw, w_rf_waddr, w_sel_rf_res, w_rdata1, w_rdata2} = r_bus;

   // ---------------------------------------------------------------
   // Operand selection (AND-OR one-hot muxes)
   // ---------------------------------------------------------------
   logic [31:0] w_imm_sext;
   logic [31:0] w_imm_zext;
   logic [31:0] w_src1;
   logic [31:0] w_src2;

   assign w_imm_sext = {{16{w_inst[15]}}, w_inst[15:0]};
   assign w_imm_zext = {16'h0000, w_inst[15:0]};

   assign w_src1 = ({32{w_sel_src1[0]}} & w_rdata1)
                 | ({32{w_sel_src1[1]}} & w_pc)
                 | ({32{w_sel_src1[2]}} & {27'd0, w_inst[10:6]});

   assign w_src2 = ({32{w_sel_src2[0]}} & w_rdata2)
                 | ({32{w_sel_src2[1]}} & w_imm_sext)
                 | ({32{w_sel_src2[2]}} & 32'd8)
                 | ({32{w_sel_src2[3]}} & w_imm_zext);

   // ---------------------------------------------------------------
   // ALU (one-hot op: add sub slt sltu and nor or xor sll srl sra lui)
   // ---------------------------------------------------------------
   logic [31:0] w_add_res;
   logic [31:0] w_sub_res;
   logic [31:0] w_slt_res;
   logic [31:0] w_sltu_res;
   logic [31:0] w_sra_res;
   logic [31:0] w_alu_res;

   assign w_add_res  = w_src1 + w_src2;
   assign w_sub_res  = w_src1 - w_src2;
   assign w_slt_res  = {31'd0, ($signed(w_src1) < $signed(w_src2))};
   assign w_sltu_res = {31'd0, (w_src1 < w_src2)};
   assign w_sra_res  = $signed(w_src2) >>> w_src1[4:0];

   assign w_alu_res = ({32{w_alu_op[11]}} & w_add_res)
                    | ({32{w_alu_op[10]}} & w_sub_res)
                    | ({32{w_alu_op[9]}}  & w_slt_res)
                    | ({32{w_alu_op[8]}}  & w_sltu_res)
                    | ({32{w_alu_op[7]}}  & (w_src1 & w_src2))
                    | ({32{w_alu_op[6]}}  & ~(w_src1 | w_src2))
                    | ({32{w_alu_op[5]}}  & (w_src1 | w_src2))
                    | ({32{w_alu_op[4]}}  & (w_src1 ^ w_src2))
                    | ({32{w_alu_op[3]}}  & (w_src2 << w_src1[4:0]))
                    | ({32{w_alu_op[2]}}  & (w_src2 >> w_src1[4:0]))
                    | ({32{w_alu_op[1]}}  & w_sra_res)
                    | ({32{w_alu_op[0]}}  & {w_src2[15:0], 16'h0000});

   // ---------------------------------------------------------------
   // Special-instruction decode
   // ---------------------------------------------------------------
   logic w_op_special;
   logic w_is_div;
   logic w_is_divu;
   logic w_div_op;
   logic w_is_mfhi;
   logic w_is_mflo;

   assign w_op_special = (w_inst[31:26] == 6'h00);
   assign w_is_div     = w_op_special && (w_inst[5:0] == 6'h1A);
   assign w_is_divu    = w_op_special && (w_inst[5:0] == 6'h1B);
   assign w_div_op     = w_is_div || w_is_divu;
   assign w_is_mfhi    = w_op_special && (w_inst[5:0] == 6'h10);
   assign w_is_mflo    = w_op_special && (w_inst[5:0] == 6'h12);

   // ---------------------------------------------------------------
   // Divider
   // ---------------------------------------------------------------
   div_state_e  r_state;
   div_state_e  w_state_nxt;
   logic [4:0]  r_cnt;
   logic [63:0] r_rq;          // {remainder, quotient} working register
   logic [31:0] r_div_b;       // divisor magnitude
   logic        r_neg_q;
   logic        r_neg_r;
   logic [31:0] r_hi;
   logic [31:0] r_lo;
   logic        w_div_start;
   logic        w_div_step;
   logic        w_div_commit;

   logic [31:0] w_abs_a;
   logic [31:0] w_abs_b;
   logic [32:0] w_part;        // remainder shifted left by one, 33 bits wide
   logic [33:0] w_diff;
   logic        w_borrow;
   logic [63:0] w_rq_step;
   logic [31:0] w_quo_fix;
   logic [31:0] w_rem_fix;
   logic        w_div_zero;

   assign w_abs_a = (w_is_div && w_rdata1[31]) ? (32'd0 - w_rdata1) : w_rdata1;
   assign w_abs_b = (w_is_div && w_rdata2[31]) ? (32'd0 - w_rdata2) : w_rdata2;

   // The shifted remainder can reach 33 bits, so compare with a 34-bit difference.
   assign w_part    = r_rq[63:31];
   assign w_diff    = {1'b0, w_part} - {2'b00, r_div_b};
   assign w_borrow  = w_diff[33];
   assign w_rq_step = w_borrow ? {w_part[31:0], r_rq[30:0], 1'b0}
                               : {w_diff[31:0], r_rq[30:0], 1'b1};

   // Divide by zero keeps the architectural convention: all-ones quotient, raw dividend remainder.
   assign w_div_zero = (w_rdata2 == 32'd0);
   assign w_quo_fix  = w_div_zero ? 32'hFFFF_FFFF
                                  : (r_neg_q ? (32'd0 - r_rq[31:0]) : r_rq[31:0]);
   assign w_rem_fix  = w_div_zero ? w_rdata1
                                  : (r_neg_r ? (32'd0 - r_rq[63:32]) : r_rq[63:32]);

   // Divider state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Divider next-state, datapath strobes and stall request; losing the DIV from the register aborts
   always_comb begin
      w_state_nxt     = r_state;
      w_div_start     = 1'b0;
      w_div_step      = 1'b0;
      w_div_commit    = 1'b0;
      stallreq_for_ex = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_div_op) begin
               w_div_start     = 1'b1;
               stallreq_for_ex = 1'b1;
               w_state_nxt     = S_RUN;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_RUN: begin
            if (!w_div_op) begin
               w_state_nxt = S_IDLE;
            end else if (r_cnt == 5'd31) begin
               w_div_step      = 1'b1;
               stallreq_for_ex = 1'b1;
               w_state_nxt     = S_DONE;
            end else begin
               w_div_step      = 1'b1;
               stallreq_for_ex = 1'b1;
               w_state_nxt     = S_RUN;
            end
         end
         S_DONE: begin
            if (w_div_op) begin
               w_div_commit = 1'b1;
            end else begin
               w_div_commit = 1'b0;
            end
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Divider datapath: latch operands on start, one restoring step per RUN cycle, write HI/LO on commit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rq    <= 64'd0;
         r_div_b <= 32'd0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_cnt   <= 5'd0;
         r_hi    <= 32'd0;
         r_lo    <= 32'd0;
      end else begin
         if (w_div_start) begin
            r_rq    <= {32'd0, w_abs_a};
            r_div_b <= w_abs_b;
            r_neg_q <= w_is_div && (w_rdata1[31] ^ w_rdata2[31]);
            r_neg_r <= w_is_div && w_rdata1[31];
            r_cnt   <= 5'd0;
         end else if (w_div_step) begin
            r_rq  <= w_rq_step;
            r_cnt <= r_cnt + 5'd1;
         end
         if (w_div_commit) begin
            r_lo <= w_quo_fix;
            r_hi <= w_rem_fix;
         end
      end
   end

   // ---------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------
   logic [31:0] w_result;
   logic        w_rf_we;

   assign w_result = w_is_mfhi ? r_hi : (w_is_mflo ? r_lo : w_alu_res);
   assign w_rf_we  = w_rf_we_raw && !w_div_op;

   assign ex_to_mem_bus   = {w_pc, w_ram_en, w_ram_wen, w_sel_rf_res, w_rf_we, w_rf_waddr, w_result};
   assign ex_to_id_fwd    = {w_rf_we, w_rf_waddr, w_result};
   assign data_sram_en    = w_ram_en;
   assign data_sram_wen   = w_ram_wen;
   assign data_sram_addr  = w_alu_res;
   assign data_sram_wdata = w_rdata2;

   // Stall bits owned by other stages and instruction fields not needed here
   logic w_unused;
   assign w_unused = ^{stall[STALL_WD-1:4], stall[1:0], w_inst[25:16]};

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage: ALU paths, SRAM request,
// stall/bubble rules, divider timing and results, async reset abort.
module tb_ex_stage;

   logic         clk;
   logic         rst;
   logic [5:0]   stall;
   logic [158:0] id_to_ex_bus;
   logic [75:0]  ex_to_mem_bus;
   logic [37:0]  ex_to_id_fwd;
   logic         data_sram_en;
   logic [3:0]   data_sram_wen;
   logic [31:0]  data_sram_addr;
   logic [31:0]  data_sram_wdata;
   logic         stallreq_for_ex;

   int n_vec  = 0;
   int n_miss = 0;

   ex_stage #(.ID_TO_EX_WD(159), .EX_TO_MEM_WD(76), .STALL_WD(6)) dut (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .id_to_ex_bus    (id_to_ex_bus),
      .ex_to_mem_bus   (ex_to_mem_bus),
      .ex_to_id_fwd    (ex_to_id_fwd),
      .data_sram_en    (data_sram_en),
      .data_sram_wen   (data_sram_wen),
      .data_sram_addr  (data_sram_addr),
      .data_sram_wdata (data_sram_wdata),
      .stallreq_for_ex (stallreq_for_ex)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [75:0] obs, input logic [75:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_miss++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [158:0] mk(
      input logic [31:0] pc, input logic [31:0] inst, input logic [11:0] op,
      input logic [2:0] s1, input logic [3:0] s2, input logic en, input logic [3:0] wen,
      input logic we, input logic [4:0] wa, input logic sel,
      input logic [31:0] r1, input logic [31:0] r2);
      return {pc, inst, op, s1, s2, en, wen, we, wa, sel, r1, r2};
   endfunction

   task automatic cyc;
      @(posedge clk);
      @(negedge clk);
   endtask

   localparam logic [31:0] MFLO_I = 32'h0000_4012;
   localparam logic [31:0] MFHI_I = 32'h0000_4010;

   // Runs a division already sitting in EX; returns the number of stallreq cycles.
   task automatic run_div(input logic [158:0] b, output int n);
      id_to_ex_bus = b;
      stall = 6'b000000;
      cyc();
      chk("div_rf_we_off", 76'(ex_to_id_fwd[37]), 76'(1'b0));
      stall = 6'b001111;
      n = 0;
      while (stallreq_for_ex && n < 100) begin
         n++;
         cyc();
      end
      stall = 6'b000000;
   endtask

   int n_cyc;

   initial begin
      rst = 1'b1;
      stall = 6'b000000;
      id_to_ex_bus = '0;
      #2;
      chk("rst_mem_bus", ex_to_mem_bus, 76'd0);
      chk("rst_fwd",     76'(ex_to_id_fwd), 76'd0);
      chk("rst_sram",    76'({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata}), 76'd0);
      chk("rst_stallreq", 76'(stallreq_for_ex), 76'd0);
      @(negedge clk);
      rst = 1'b0;

      // ORI: 0x1200 | 0x0034
      id_to_ex_bus = mk(32'hBFC0_0000, 32'h3422_0034, 12'h020, 3'b001, 4'b1000,
                        1'b0, 4'h0, 1'b1, 5'd2, 1'b0, 32'h0000_1200, 32'h0000_0000);
      cyc();
      chk("ori_mem_bus", ex_to_mem_bus,
          {32'hBFC0_0000, 1'b0, 4'h0, 1'b0, 1'b1, 5'd2, 32'h0000_1234});
      chk("ori_fwd", 76'(ex_to_id_fwd), 76'({1'b1, 5'd2, 32'h0000_1234}));

      // ADDIU wraps modulo 2^32
      id_to_ex_bus = mk(32'hBFC0_0004, 32'h2423_0002, 12'h800, 3'b001, 4'b0010,
                        1'b0, 4'h0, 1'b1, 5'd3, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000);
      cyc();
      chk("addiu_wrap", 76'(ex_to_mem_bus[31:0]), 76'(32'h0000_0001));

      // LUI
      id_to_ex_bus = mk(32'hBFC0_0008, 32'h3C04_ABCD, 12'h001, 3'b000, 4'b0010,
                        1'b0, 4'h0, 1'b1, 5'd4, 1'b0, 32'h1111_1111, 32'h2222_2222);
      cyc();
      chk("lui", 76'(ex_to_mem_bus[31:0]), 76'(32'hABCD_0000));

      // SUB 5 - 7
      id_to_ex_bus = mk(32'hBFC0_000C, 32'h0000_0023, 12'h400, 3'b001, 4'b0001,
                        1'b0, 4'h0, 1'b1, 5'd5, 1'b0, 32'd5, 32'd7);
      cyc();
      chk("sub", 76'(ex_to_mem_bus[31:0]), 76'(32'hFFFF_FFFE));

      // SLT signed: -1 < 1
      id_to_ex_bus = mk(32'hBFC0_0010, 32'h0000_002A, 12'h200, 3'b001, 4'b0001,
                        1'b0, 4'h0, 1'b1, 5'd5, 1'b0, 32'hFFFF_FFFF, 32'd1);
      cyc();
      chk("slt", 76'(ex_to_mem_bus[31:0]), 76'(32'd1));

      // SLTU: 0xFFFFFFFF < 1 is false
      id_to_ex_bus = mk(32'hBFC0_0014, 32'h0000_002B, 12'h100, 3'b001, 4'b0001,
                        1'b0, 4'h0, 1'b1, 5'd5, 1'b0, 32'hFFFF_FFFF, 32'd1);
      cyc();
      chk("sltu", 76'(ex_to_mem_bus[31:0]), 76'(32'd0));

      // SRA by sa=4 from inst[10:6]
      id_to_ex_bus = mk(32'hBFC0_0018, 32'h0002_1903, 12'h002, 3'b100, 4'b0001,
                        1'b0, 4'h0, 1'b1, 5'd3, 1'b0, 32'h0000_0000, 32'h8000_0000);
      cyc();
      chk("sra", 76'(ex_to_mem_bus[31:0]), 76'(32'hF800_0000));

      // NOR
      id_to_ex_bus = mk(32'hBFC0_001C, 32'h0000_0027, 12'h040, 3'b001, 4'b0001,
                        1'b0, 4'h0, 1'b1, 5'd3, 1'b0, 32'hF0F0_0000, 32'h0000_00FF);
      cyc();
      chk("nor", 76'(ex_to_mem_bus[31:0]), 76'(32'h0F0F_FF00));

      // Link address: pc + 8
      id_to_ex_bus = mk(32'hBFC0_0020, 32'h0C00_0000, 12'h800, 3'b010, 4'b0100,
                        1'b0, 4'h0, 1'b1, 5'd31, 1'b0, 32'h0000_0000, 32'h0000_0000);
      cyc();
      chk("pc_plus_8", 76'(ex_to_mem_bus[31:0]), 76'(32'hBFC0_0028));

      // alu_op all zero
      id_to_ex_bus = mk(32'hBFC0_0024, 32'h0000_0000, 12'h000, 3'b001, 4'b0001,
                        1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
      cyc();
      chk("aluop_zero", 76'(ex_to_mem_bus[31:0]), 76'(32'd0));

      // SW: addr = 0x1000 + sext(0xFFFC)
      id_to_ex_bus = mk(32'hBFC0_0028, 32'hAC25_FFFC, 12'h800, 3'b001, 4'b0010,
                        1'b1, 4'hF, 1'b0, 5'd0, 1'b0, 32'h0000_1000, 32'hDEAD_BEEF);
      cyc();
      chk("sw_sram", 76'({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata}),
          76'({1'b1, 4'hF, 32'h0000_0FFC, 32'hDEAD_BEEF}));

      // Hold: stall[2]=1, stall[3]=1 keeps the store in EX
      stall = 6'b001100;
      id_to_ex_bus = mk(32'hBFC0_002C, 32'h3422_0034, 12'h020, 3'b001, 4'b1000,
                        1'b0, 4'h0, 1'b1, 5'd2, 1'b0, 32'h0000_0055, 32'h0000_0000);
      cyc();
      chk("hold_sram", 76'({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata}),
          76'({1'b1, 4'hF, 32'h0000_0FFC, 32'hDEAD_BEEF}));

      // Bubble: stall[2]=1, stall[3]=0 loads zero
      stall = 6'b000100;
      cyc();
      chk("bubble_en", 76'(data_sram_en), 76'(1'b0));
      chk("bubble_bus", ex_to_mem_bus, 76'd0);
      stall = 6'b000000;

      // HI before any division is the reset value
      id_to_ex_bus = mk(32'hBFC0_0030, MFHI_I, 12'h000, 3'b000, 4'b0000,
                        1'b0, 4'h0, 1'b1, 5'd8, 1'b0, 32'd0, 32'd0);
      cyc();
      chk("mfhi_init", 76'(ex_to_mem_bus[31:0]), 76'(32'd0));

      // DIV signed -7 / 2
      run_div(mk(32'hBFC0_0040, 32'h0085_001A, 12'h000, 3'b000, 4'b0000,
                 1'b0, 4'h0, 1'b1, 5'd0, 1'b0, 32'hFFFF_FFF9, 32'd2), n_cyc);
      chk("div_stall_cycles", 76'(n_cyc), 76'(33));
      id_to_ex_bus = mk(32'hBFC0_0044, MFLO_I, 12'h000, 3'b000, 4'b0000,
                        1'b0, 4'h0, 1'b1, 5'd8, 1'b0, 32'd0, 32'd0);
      cyc();
      chk("div_lo", 76'(ex_to_mem_bus[31:0]), 76'(32'hFFFF_FFFD));
      id_to_ex_bus = mk(32'hBFC0_0048, MFHI_I, 12'h000, 3'b000, 4'b0000,
                        1'b0, 4'h0, 1'b1, 5'd8, 1'b0, 32'd0, 32'd0);
      cyc();
      chk("div_hi", 76'(ex_to_mem_bus[31:0]), 76'(32'hFFFF_FFFF));

      // DIVU 100 / 7
      run_div(mk(32'hBFC0_0050, 32'h0085_001B, 12'h000, 3'b000, 4'b0000,
                 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 32'd100, 32'd7), n_cyc);
      chk("divu_stall_cycles", 76'(n_cyc), 76'(33));
      id_to_ex_bus = mk(32'hBFC0_0054, MFLO_I, 12'h000, 3'b000, 4'b0000,
                        1'b0, 4'h0, 1'b1, 5'd8, 1'b0, 32'd0, 32'd0);
      cyc();
      chk("divu_lo", 76'(ex_to_mem_bus[31:0]), 76'(32'd14));
      id_to_ex_bus = mk(32'hBFC0_0058, MFHI_I, 12'h000, 3'b000, 4'b0000,
                        1'b0, 4'h0, 1'b1, 5'd8, 1'b0, 32'd0, 32'd0);
      cyc();
      chk("divu_hi", 76'(ex_to_mem_bus[31:0]), 76'(32'd2));

      // DIVU by zero
      run_div(mk(32'hBFC0_0060, 32'h0085_001B, 12'h000, 3'b000, 4'b0000,
                 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 32'h0000_1234, 32'd0), n_cyc);
      chk("dz_stall_cycles", 76'(n_cyc), 76'(33));
      id_to_ex_bus = mk(32'hBFC0_0064, MFLO_I, 12'h000, 3'b000, 4'b0000,
                        1'b0, 4'h0, 1'b1, 5'd8, 1'b0, 32'd0, 32'd0);
      cyc();
      chk("dz_lo", 76'(ex_to_mem_bus[31:0]), 76'(32'hFFFF_FFFF));
      id_to_ex_bus = mk(32'hBFC0_0068, MFHI_I, 12'h000, 3'b000, 4'b0000,
                        1'b0, 4'h0, 1'b1, 5'd8, 1'b0, 32'd0, 32'd0);
      cyc();
      chk("dz_hi", 76'(ex_to_mem_bus[31:0]), 76'(32'h0000_1234));

      // Async reset at RUN step 10
      id_to_ex_bus = mk(32'hBFC0_0070, 32'h0085_001A, 12'h000, 3'b000, 4'b0000,
                        1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 32'd100, 32'd7);
      stall = 6'b000000;
      cyc();
      stall = 6'b001111;
      repeat (11) cyc();
      chk("mid_run_stallreq", 76'(stallreq_for_ex), 76'(1'b1));
      #2 rst = 1'b1;
      #1;
      chk("rst_stallreq_drop", 76'(stallreq_for_ex), 76'(1'b0));
      chk("rst_bus_clear", ex_to_mem_bus, 76'd0);
      @(negedge clk);
      rst = 1'b0;
      stall = 6'b000000;
      id_to_ex_bus = mk(32'hBFC0_0074, MFHI_I, 12'h000, 3'b000, 4'b0000,
                        1'b0, 4'h0, 1'b1, 5'd8, 1'b0, 32'd0, 32'd0);
      cyc();
      chk("rst_hi_zero", 76'(ex_to_mem_bus[31:0]), 76'(32'd0));
      id_to_ex_bus = mk(32'hBFC0_0078, MFLO_I, 12'h000, 3'b000, 4'b0000,
                        1'b0, 4'h0, 1'b1, 5'd8, 1'b0, 32'd0, 32'd0);
      cyc();
      chk("rst_lo_zero", 76'(ex_to_mem_bus[31:0]), 76'(32'd0));

      // Next DIV after reset completes normally
      run_div(mk(32'hBFC0_0080, 32'h0085_001A, 12'h000, 3'b000, 4'b0000,
                 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 32'd100, 32'd7), n_cyc);
      chk("post_rst_stall_cycles", 76'(n_cyc), 76'(33));
      id_to_ex_bus = mk(32'hBFC0_0084, MFLO_I, 12'h000, 3'b000, 4'b0000,
                        1'b0, 4'h0, 1'b1, 5'd8, 1'b0, 32'd0, 32'd0);
      cyc();
      chk("post_rst_lo", 76'(ex_to_mem_bus[31:0]), 76'(32'd14));
      id_to_ex_bus = mk(32'hBFC0_0088, MFHI_I, 12'h000, 3'b000, 4'b0000,
                        1'b0, 4'h0, 1'b1, 5'd8, 1'b0, 32'd0, 32'd0);
      cyc();
      chk("post_rst_hi", 76'(ex_to_mem_bus[31:0]), 76'(32'd2));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
